// File: rtl/quadra_pipe_pkg.sv
// quadra_pipe_pkg: shared widths, types and helpers for the piecewise-quadratic
// evaluator. The width localparams are the single point of configuration for the
// block, its coefficient table and its bus interface.
//   Types  : x_t, seg_t, off_t, a_t, b_t, c_t, acc_t, y_t, y_res_t
//   Consts : ACC_W, CFG_SEL_A/B/C, Y_MAX/Y_MIN
//   Funcs  : sat_y() clamps a shifted sum into y_t and flags saturation
package quadra_pipe_pkg;
    localparam int SEG_W     = 7;
    localparam int OFF_W     = 17;
    localparam int A_W       = 30;
    localparam int B_W       = 24;
    localparam int C_W       = 18;
    localparam int Y_W       = 25;
    localparam int OUT_SHIFT = 4;

    localparam int NSEG  = 2 ** SEG_W;
    localparam int X_W   = SEG_W + OFF_W;
    localparam int ACC_W = A_W + 2;

    localparam logic [1:0] CFG_SEL_A = 2'd0;
    localparam logic [1:0] CFG_SEL_B = 2'd1;
    localparam logic [1:0] CFG_SEL_C = 2'd2;

    typedef logic        [X_W-1:0]   x_t;
    typedef logic        [SEG_W-1:0] seg_t;
    typedef logic        [OFF_W-1:0] off_t;
    typedef logic signed [A_W-1:0]   a_t;
    typedef logic signed [B_W-1:0]   b_t;
    typedef logic signed [C_W-1:0]   c_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [Y_W-1:0]   y_t;

    typedef struct packed {
        logic sat;
        y_t   y;
    } y_res_t;

    localparam acc_t Y_MAX = acc_t'(2 ** (Y_W - 1) - 1);
    localparam acc_t Y_MIN = acc_t'(-(2 ** (Y_W - 1)));

    function automatic y_res_t sat_y(input acc_t s);
        y_res_t r;
        if (s > Y_MAX) begin
            r.sat = 1'b1;
            r.y   = y_t'(Y_MAX);
        end else if (s < Y_MIN) begin
            r.sat = 1'b1;
            r.y   = y_t'(Y_MIN);
        end else begin
            r.sat = 1'b0;
            r.y   = y_t'(s);
        end
        return r;
    endfunction
endpackage

// File: rtl/quadra_pipe_if.sv
// quadra_pipe_if: sample/result handshake plus coefficient-write bus.
//   master : sample source / result sink / configuration agent
//   slave  : quadra_pipe
interface quadra_pipe_if;
    import quadra_pipe_pkg::*;

    logic       in_valid;
    logic       in_ready;
    x_t         x;
    logic       out_valid;
    logic       out_ready;
    y_t         y;
    logic       sat;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    seg_t       cfg_addr;
    a_t         cfg_wdata;

    modport master (
        output in_valid, x, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, y, sat
    );

    modport slave (
        input  in_valid, x, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output in_ready, out_valid, y, sat
    );
endinterface

// File: rtl/quadra_coef_tbl.sv
// quadra_coef_tbl: NSEG-entry a/b/c coefficient register file.
//   clk, rst_b          : clock, synchronous active-high reset (clears all entries)
//   cfg_we/sel/addr/wdata : single write port; sel 3 writes nothing
//   rd_addr -> rd_a/b/c : combinational read of the registered contents, so a
//                         read in the cycle of a write sees the old entry
module quadra_coef_tbl
    import quadra_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic       cfg_we,
    input  logic [1:0] cfg_sel,
    input  seg_t       cfg_addr,
    input  a_t         cfg_wdata,
    input  seg_t       rd_addr,
    output a_t         rd_a,
    output b_t         rd_b,
    output c_t         rd_c
);
    a_t a_mem [NSEG];
    b_t b_mem [NSEG];
    c_t c_mem [NSEG];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < NSEG; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
                c_mem[i] <= '0;
            end
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_A: a_mem[cfg_addr] <= cfg_wdata;
                CFG_SEL_B: b_mem[cfg_addr] <= cfg_wdata[B_W-1:0];
                CFG_SEL_C: c_mem[cfg_addr] <= cfg_wdata[C_W-1:0];
                default:   ;
            endcase
        end
    end

    assign rd_a = a_mem[rd_addr];
    assign rd_b = b_mem[rd_addr];
    assign rd_c = c_mem[rd_addr];
endmodule

// File: rtl/quadra_pipe.sv
// quadra_pipe: 3-stage piecewise-quadratic evaluator
//   y = sat((a[seg] + (b[seg]*x2 >>> OFF_W) + (c[seg]*sq >>> OFF_W)) >>> OUT_SHIFT)
//   with sq = x2*x2 >> OFF_W and x = {seg, x2}.
//   clk   : clock, rising edge
//   rst_b : synchronous active-high reset; flushes pipe and coefficient table
//   bus   : quadra_pipe_if.slave (valid/ready in/out + coefficient writes)
// All stages share one advance enable, so a stalled output freezes the whole
// pipe and bubbles are kept rather than collapsed.
module quadra_pipe
    import quadra_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst_b,
    quadra_pipe_if.slave bus
);
    logic               en, acc_in;
    logic [3:1]         vld_pipe;
    seg_t               seg_in;
    off_t               x2_in, sq_in;
    logic [2*OFF_W-1:0] x2_sq;
    a_t                 tbl_a, s1_a;
    b_t                 tbl_b, s1_b;
    c_t                 tbl_c, s1_c;
    off_t               s1_x2, s1_sq;
    logic signed [B_W+OFF_W:0] p1;
    logic signed [C_W+OFF_W:0] p2;
    acc_t               s2_t0, s2_t1, s2_t2, sum, s_shr;
    y_res_t             res;
    y_t                 y_q;
    logic               sat_q;

    assign en           = !vld_pipe[3] | bus.out_ready;
    assign bus.in_ready = en & !rst_b;
    assign acc_in       = bus.in_valid & bus.in_ready;

    assign seg_in = bus.x[X_W-1:OFF_W];
    assign x2_in  = bus.x[OFF_W-1:0];
    assign x2_sq  = {{OFF_W{1'b0}}, x2_in} * {{OFF_W{1'b0}}, x2_in};
    // x2 < 1.0, so the top half of the square always fits OFF_W bits
    assign sq_in  = off_t'(x2_sq >> OFF_W);

    quadra_coef_tbl u_tbl (
        .clk      (clk),
        .rst_b    (rst_b),
        .cfg_we   (bus.cfg_we),
        .cfg_sel  (bus.cfg_sel),
        .cfg_addr (bus.cfg_addr),
        .cfg_wdata(bus.cfg_wdata),
        .rd_addr  (seg_in),
        .rd_a     (tbl_a),
        .rd_b     (tbl_b),
        .rd_c     (tbl_c)
    );

    // Operands pre-extended to the full product width; x2/sq are unsigned
    // fractions, so they get a zero sign bit before the signed multiply.
    assign p1 = $signed({{(OFF_W+1){s1_b[B_W-1]}}, s1_b})
              * $signed({{B_W{1'b0}}, 1'b0, s1_x2});
    assign p2 = $signed({{(OFF_W+1){s1_c[C_W-1]}}, s1_c})
              * $signed({{C_W{1'b0}}, 1'b0, s1_sq});

    assign sum   = s2_t0 + s2_t1 + s2_t2;
    assign s_shr = sum >>> OUT_SHIFT;
    assign res   = sat_y(s_shr);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            vld_pipe <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_x2    <= '0;
            s1_sq    <= '0;
            s2_t0    <= '0;
            s2_t1    <= '0;
            s2_t2    <= '0;
            y_q      <= '0;
            sat_q    <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[2:1], acc_in};
            s1_a     <= tbl_a;
            s1_b     <= tbl_b;
            s1_c     <= tbl_c;
            s1_x2    <= x2_in;
            s1_sq    <= sq_in;
            s2_t0    <= acc_t'(s1_a);
            s2_t1    <= acc_t'(p1 >>> OFF_W);
            s2_t2    <= acc_t'(p2 >>> OFF_W);
            y_q      <= res.y;
            sat_q    <= res.sat;
        end
    end

    assign bus.out_valid = vld_pipe[3];
    assign bus.y         = y_q;
    assign bus.sat       = sat_q;
endmodule

// File: doc/quadra_pipe.md
Name: quadra_pipe

Overview:
- Parametrised piecewise-quadratic function evaluator: y = a[seg] + b[seg]*x2 + c[seg]*x2^2, where x = {seg, x2}.
- Successor to the fixed-table 3-stage evaluator. Adds:
  - run-time writable coefficient table;
  - valid/ready handshake with backpressure;
  - parametrised widths;
  - output saturation with a flag.
- Sits between the input sample source and the downstream datapath.

Parameters:
- SEG_W, 7, segment index width; NSEG = 2**SEG_W table entries.
- OFF_W, 17, offset (x2) width, unsigned fraction in [0,1).
- A_W, 30, signed width of a; also the config write data width.
- B_W, 24, signed width of b.
- C_W, 18, signed width of c.
- Y_W, 25, signed output width.
- OUT_SHIFT, 4, arithmetic right shift applied to the sum before saturation.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  synchronous reset, active-high (asserted = 1).
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- x  in  SEG_W+OFF_W  input sample; [MSB:OFF_W] = seg, [OFF_W-1:0] = x2.
- out_valid  out  1  y/sat valid.
- out_ready  in  1  downstream accepts y.
- y  out  Y_W  signed result.
- sat  out  1  y was clamped.
- cfg_we  in  1  coefficient write strobe.
- cfg_sel  in  2  0 = a, 1 = b, 2 = c, 3 = ignored (no write).
- cfg_addr  in  SEG_W  segment to write.
- cfg_wdata  in  A_W  coefficient value; low B_W/C_W bits used for b/c.

Behaviour:
- Reset (rst_b = 1 at clk edge):
  - out_valid, y, sat, all stage valids and stage registers -> 0;
  - all coefficient entries -> 0;
  - in-flight samples are discarded;
  - in_ready = 0 while rst_b = 1.
- Pipeline:
  - Three register stages S1, S2, S3 with a global advance: en = !out_valid | out_ready; in_ready = en & !rst_b.
  - A sample is accepted when in_valid & in_ready.
  - When all stages advance each cycle, y appears with out_valid = 1 exactly 3 cycles after acceptance.
  - Bubbles are not collapsed; throughput is 1 sample/cycle while out_ready = 1.
- S1:
  - Register a, b, c read from the table at seg.
  - Register x2 and sq = (x2*x2) >> OFF_W (unsigned, OFF_W bits).
- S2:
  - t0 = a (sign-extended);
  - t1 = (b * $signed({1'b0,x2})) >>> OFF_W;
  - t2 = (c * $signed({1'b0,sq})) >>> OFF_W;
  - all terms carried at full precision in ACC_W = A_W + 2 bits.
- S3:
  - s = (t0 + t1 + t2) >>> OUT_SHIFT (floor truncation);
  - if s > 2**(Y_W-1)-1 or s < -2**(Y_W-1): y = clamp value, sat = 1;
  - otherwise y = s[Y_W-1:0], sat = 0.
- Stall: while out_valid & !out_ready, all stage registers, y and sat hold stable. A valid output is never dropped or duplicated.
- Coefficient writes:
  - Accepted every cycle regardless of pipeline state.
  - The write commits at the clk edge.
  - An S1 read in the same cycle as a write to the same entry returns the old value.
  - Samples accepted in later cycles see the new value.
  - Samples already past S1 are unaffected.
- Reset mid-operation: flush as above; the first sample after release uses the zeroed table unless rewritten.

Decomposition:
- Shared package quadra_pipe_pkg holds:
  - typedefs: x_t, seg_t, off_t, a_t, b_t, c_t, acc_t, y_t;
  - constants: ACC_W, CFG_SEL_A/B/C;
  - functions: sat_y() clamp function.
- Sub-module quadra_coef_tbl:
  - NSEG x (A_W+B_W+C_W) register file;
  - synchronous reset, one write port (sel/addr/data), one combinational read port;
  - read-during-write returns the old value.

Test Plan:
1. Write a[5] = 1000, b[5] = c[5] = 0; send x = {7'd5, 17'd0} with out_ready = 1 -> y = 62, sat = 0, out_valid exactly 3 cycles after accept.
2. b[3] = 2^20, a = c = 0; x = {7'd3, 17'd65536} -> t1 = 2^19 -> y = 32768.
3. c[9] = 2^16, a = b = 0; x = {7'd9, 17'd65536} -> sq = 2^15, t2 = 2^14 -> y = 1024.
4. Saturation and mixed-coefficient write, then two samples:
   - a[0] = 2^29-1 -> y = 16777215, sat = 1;
   - a[0] = -2^29 -> y = -16777216, sat = 1.
5. Stream 10 back-to-back samples from test 1/2/3 segments while out_ready toggles 1,0,0,1,... -> outputs in order, none lost or duplicated; y stable while stalled; in_ready = 0 exactly when out_valid & !out_ready.
6. Hazard and reset cases:
   - write a[5] = 2000 in the same cycle a seg-5 sample is accepted -> that sample yields 62, the next yields 125;
   - assert rst_b with 3 samples in flight -> out_valid = 0 next cycle, table zeroed, first post-reset seg-5 sample yields y = 0.
